// File: rtl/mdr_unit_if.sv
// Datapath/memory-side signal bundle for mdr_unit; master drives the requests,
// slave is the MDR block itself.
interface mdr_unit_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] bus_in;
    logic              mdr_in;
    logic              read;
    logic              mem_rdy;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mdr_q;
    logic              mem_req;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output bus_in, mdr_in, read, mem_rdy, mem_data_in,
        input  mdr_q, mem_req, busy, done, err
    );

    modport slave (
        input  bus_in, mdr_in, read, mem_rdy, mem_data_in,
        output mdr_q, mem_req, busy, done, err
    );
endinterface

// File: rtl/mdr_unit.sv
// Memory data register with an IDLE/WAIT/DONE read sequencer.
// Define MDR_TIMEOUT_EN to add a WAIT-state timeout that sets a sticky err flag.
module mdr_unit #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic      clk,
    input  logic      clr_n,
    mdr_unit_if.slave mdr
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mdr_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              mem_req_q, busy_q, done_q;

`ifdef MDR_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       timeout;

    // The current WAIT cycle is the last one allowed when the count is one short of the limit.
    assign timeout = (cnt_q + 8'd1) == TIMEOUT_LIM;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        mdr_d   = mdr_q;
`ifdef MDR_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (mdr.read) begin
                    state_d = S_WAIT;
`ifdef MDR_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end else if (mdr.mdr_in) begin
                    mdr_d = mdr.bus_in;
                end
            end
            S_WAIT: begin
                // Data arriving on the limit cycle still counts as a normal capture.
                if (mdr.mem_rdy) begin
                    mdr_d   = mdr.mem_data_in;
                    state_d = S_DONE;
                end
`ifdef MDR_TIMEOUT_EN
                else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: clr_n clears the data register as well, so mdr_q reads 0 straight after reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            mdr_q     <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            mdr_q     <= mdr_d;
            mem_req_q <= (state_d == S_WAIT);
            busy_q    <= (state_d == S_WAIT);
            done_q    <= (state_d == S_DONE);
        end
    end

`ifdef MDR_TIMEOUT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mdr.err = err_q;
`else
    assign mdr.err = 1'b0;
`endif

    assign mdr.mdr_q   = mdr_q;
    assign mdr.mem_req = mem_req_q;
    assign mdr.busy    = busy_q;
    assign mdr.done    = done_q;
endmodule

// File: tb/tb_mdr_unit.sv
// Self-checking bench for mdr_unit: IDLE load table, read sequences with a
// data scoreboard, reset abort, and timeout behaviour when MDR_TIMEOUT_EN is defined.
module tb_mdr_unit;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic clr_n;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [DW-1:0] sb_q[$];

    mdr_unit_if #(.DATA_W(DW)) ifc ();

    mdr_unit #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .mdr   (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          mdr_in;
        logic          mem_rdy;
        logic [DW-1:0] bus;
        logic [DW-1:0] mem_data;
        logic [DW-1:0] exp_mdr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // read sampled at edge N, mem_rdy sampled at edge N+k
    task automatic do_read(input logic [DW-1:0] data, input int k);
        int            req_cycles;
        logic [DW-1:0] exp;
        req_cycles = 0;
        ifc.read = 1'b1;
        tick();
        ifc.read = 1'b0;
        if (ifc.mem_req && ifc.busy) req_cycles++;
        for (int i = 1; i < k; i++) begin
            tick();
            if (ifc.mem_req && ifc.busy) req_cycles++;
        end
        ifc.mem_rdy     = 1'b1;
        ifc.mem_data_in = data;
        sb_q.push_back(data);
        tick();
        ifc.mem_rdy = 1'b0;
        check("rd_done", 32'(ifc.done), 32'd1);
        check("rd_idle_flags", {30'd0, ifc.mem_req, ifc.busy}, 32'd0);
        exp = sb_q.pop_front();
        check("rd_data", ifc.mdr_q, exp);
        check("rd_req_cycles", req_cycles, k);
        tick();
        check("rd_done_drop", 32'(ifc.done), 32'd0);
    endtask

    initial begin
        int            n;
        logic          done_seen;
        logic [DW-1:0] exp;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_00A5, 32'h0,         32'h0000_00A5};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0055, 32'h0,         32'h0000_00A5};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0066, 32'h0000_1111, 32'h0000_00A5};
        vecs[3] = '{1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_2222, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF};

        clr_n           = 1'b0;
        ifc.bus_in      = '0;
        ifc.mdr_in      = 1'b0;
        ifc.read        = 1'b0;
        ifc.mem_rdy     = 1'b0;
        ifc.mem_data_in = '0;

        tick();
        tick();
        check("rst_mdr", ifc.mdr_q, 32'd0);
        check("rst_flags", {28'd0, ifc.mem_req, ifc.busy, ifc.done, ifc.err}, 32'd0);
        clr_n = 1'b1;

        // IDLE loads, holds and ignored mem_rdy
        for (int i = 0; i < 6; i++) begin
            ifc.mdr_in      = vecs[i].mdr_in;
            ifc.mem_rdy     = vecs[i].mem_rdy;
            ifc.bus_in      = vecs[i].bus;
            ifc.mem_data_in = vecs[i].mem_data;
            tick();
            check($sformatf("vec%0d_mdr", i), ifc.mdr_q, vecs[i].exp_mdr);
            check($sformatf("vec%0d_flags", i), {29'd0, ifc.mem_req, ifc.busy, ifc.done}, 32'd0);
        end
        ifc.mdr_in  = 1'b0;
        ifc.mem_rdy = 1'b0;

        do_read(32'hDEAD_BEEF, 3);
        do_read(32'h0F0F_1234, 1);

        // read and mdr_in together: read wins, then mdr_in/read ignored in WAIT and DONE
        ifc.read   = 1'b1;
        ifc.mdr_in = 1'b1;
        ifc.bus_in = 32'h1234_5678;
        tick();
        check("both_mdr_hold", ifc.mdr_q, 32'h0F0F_1234);
        check("both_busy", 32'(ifc.busy), 32'd1);
        ifc.bus_in = 32'h9999_9999;
        tick();
        check("wait_mdr_hold", ifc.mdr_q, 32'h0F0F_1234);
        check("wait_busy", {30'd0, ifc.mem_req, ifc.busy}, 32'd3);
        ifc.read        = 1'b0;
        ifc.mdr_in      = 1'b0;
        ifc.mem_rdy     = 1'b1;
        ifc.mem_data_in = 32'h0BAD_F00D;
        sb_q.push_back(32'h0BAD_F00D);
        tick();
        ifc.mem_rdy = 1'b0;
        check("both_done", 32'(ifc.done), 32'd1);
        exp = sb_q.pop_front();
        check("both_data", ifc.mdr_q, exp);
        ifc.read   = 1'b1;
        ifc.mdr_in = 1'b1;
        ifc.bus_in = 32'h7777_7777;
        tick();
        ifc.read   = 1'b0;
        ifc.mdr_in = 1'b0;
        check("done_ignores_in", {29'd0, ifc.mem_req, ifc.busy, ifc.done}, 32'd0);
        check("done_mdr_hold", ifc.mdr_q, 32'h0BAD_F00D);

        // reset mid-WAIT aborts the read
        ifc.mdr_in = 1'b1;
        ifc.bus_in = 32'hFFFF_FFFF;
        tick();
        ifc.mdr_in = 1'b0;
        ifc.read   = 1'b1;
        tick();
        ifc.read = 1'b0;
        tick();
        check("abort_pre_busy", 32'(ifc.busy), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort_flags", {29'd0, ifc.mem_req, ifc.busy, ifc.done}, 32'd0);
        check("abort_mdr", ifc.mdr_q, 32'd0);
        tick();
        ifc.mem_rdy     = 1'b1;
        ifc.mem_data_in = 32'h4444_4444;
        clr_n           = 1'b1;
        tick();
        ifc.mem_rdy = 1'b0;
        check("late_rdy_mdr", ifc.mdr_q, 32'd0);
        check("late_rdy_flags", {29'd0, ifc.mem_req, ifc.busy, ifc.done}, 32'd0);

`ifndef MDR_TIMEOUT_EN
        // without the timeout option WAIT holds until mem_rdy
        ifc.read = 1'b1;
        tick();
        ifc.read = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifc.busy && ifc.mem_req && !ifc.err) n++;
        end
        check("long_wait", n, 40);
        ifc.mem_rdy     = 1'b1;
        ifc.mem_data_in = 32'h00C0_FFEE;
        sb_q.push_back(32'h00C0_FFEE);
        tick();
        ifc.mem_rdy = 1'b0;
        check("long_done", 32'(ifc.done), 32'd1);
        exp = sb_q.pop_front();
        check("long_data", ifc.mdr_q, exp);
        check("long_err", 32'(ifc.err), 32'd0);
        tick();
`else
        // timeout after 4 WAIT cycles, err sticky until the next read
        ifc.mdr_in = 1'b1;
        ifc.bus_in = 32'h5A5A_5A5A;
        tick();
        ifc.mdr_in = 1'b0;
        ifc.read   = 1'b1;
        tick();
        ifc.read  = 1'b0;
        n         = ifc.mem_req ? 1 : 0;
        done_seen = ifc.done;
        for (int i = 0; i < 20; i++) begin
            tick();
            done_seen = done_seen | ifc.done;
            if (!ifc.mem_req) break;
            n++;
        end
        check("to_wait_cycles", n, 4);
        check("to_err", 32'(ifc.err), 32'd1);
        check("to_no_done", 32'(done_seen), 32'd0);
        check("to_mdr_hold", ifc.mdr_q, 32'h5A5A_5A5A);
        check("to_busy", 32'(ifc.busy), 32'd0);
        tick();
        check("to_err_sticky", 32'(ifc.err), 32'd1);
        ifc.read = 1'b1;
        tick();
        ifc.read = 1'b0;
        check("to_err_cleared", 32'(ifc.err), 32'd0);
        ifc.mem_rdy     = 1'b1;
        ifc.mem_data_in = 32'h0000_0077;
        sb_q.push_back(32'h0000_0077);
        tick();
        ifc.mem_rdy = 1'b0;
        exp = sb_q.pop_front();
        check("to_next_data", ifc.mdr_q, exp);
        tick();
        do_read(32'h0000_0001, 4);
        check("limit_rdy_err", 32'(ifc.err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
